pingpong_frame_ram: RTL and testbench

- Parametrised, single-clock, double-buffered (ping-pong) frame RAM.
- The writer fills the back bank while the reader scans the front bank.
- A swap handshake exchanges the two banks only at a safe point, when the reader is idle.
- Sits between the SPI-slave pixel writer and the display scan-out reader.

---
 rtl/pingpong_frame_ram.sv | 147 ++++++++++++++
 tb/tb_pingpong_frame_ram.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_ram.sv
// Double-buffered frame RAM: writer fills the back bank, reader scans the front bank,
// banks exchange on a swap handshake while the reader is idle. BANK_CLEAR_EN adds a post-swap clear.
module pingpong_frame_ram #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic              clear_busy
);

  typedef enum logic [1:0] {StIdle, StPending, StAck, StClear} state_e;

  state_e state_q, state_d;
  logic   front_q, front_d;
  logic   req;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

`ifdef BANK_CLEAR_EN
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              swap_latch_q, swap_latch_d;

  assign req        = swap_req | swap_latch_q;
  assign clear_busy = (state_q == StClear);

  always_comb begin
    clr_cnt_d    = (state_q == StClear) ? clr_cnt_q + 1'b1 : '0;
    swap_latch_d = swap_latch_q;
    if (state_q == StIdle) swap_latch_d = 1'b0;
    // Requests that land during the clear are serviced once it finishes.
    if (state_q == StClear && swap_req) swap_latch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q    <= '0;
      swap_latch_q <= 1'b0;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      swap_latch_q <= swap_latch_d;
    end
  end
`else
  assign req        = swap_req;
  assign clear_busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!rd_en) begin
            front_d = ~front_q;
            state_d = StAck;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (!rd_en) begin
          front_d = ~front_q;
          state_d = StAck;
        end
      end
`ifdef BANK_CLEAR_EN
      StAck:   state_d = StClear;
      StClear: if (clr_cnt_q == LastAddr) state_d = StIdle;
`else
      StAck:   state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
    end
  end

  // Back bank is always ~front_q; the clear walker takes the port over from the writer.
  always_comb begin
    mem_we    = wr_en && (32'(wr_addr) < DEPTH);
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
`ifdef BANK_CLEAR_EN
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we && front_q)  mem0[mem_waddr] <= mem_wdata;
    if (mem_we && !front_q) mem1[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (32'(rd_addr) < DEPTH) rd_data_q <= front_q ? mem1[rd_addr] : mem0[rd_addr];
        else                      rd_data_q <= '0;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign swap_ack   = (state_q == StAck);
  assign front_bank = front_q;

endmodule

// File: tb/tb_pingpong_frame_ram.sv
// Randomised bench for pingpong_frame_ram against a behavioural bank/swap model,
// plus directed literal checks of the swap, pending, reset and (BANK_CLEAR_EN) clear behaviour.
module tb_pingpong_frame_ram;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              swap_req = 1'b0;
  logic              swap_ack;
  logic              front_bank;
  logic              clear_busy;

  int n_vec = 0;
  int n_err = 0;

  pingpong_frame_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front_bank (front_bank),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: bank contents, which bank is in front, and the swap/clear progress.
  int m_mem   [2][DEPTH];
  bit m_known [2][DEPTH];
  int m_front = 0;
  bit m_pend = 0, m_ack = 0, m_latch = 0, m_valid = 0, m_rd_known = 1;
  int m_clear_left = 0;
  int m_rd = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_front = 0; m_pend = 0; m_ack = 0; m_latch = 0; m_valid = 0;
      m_clear_left = 0; m_rd = 0; m_rd_known = 1;
    end else begin
      bit busy;
      int back;
      busy = (m_clear_left > 0);
      back = 1 - m_front;
      if (wr_en && !busy && int'(wr_addr) < DEPTH) begin
        m_mem[back][wr_addr] = int'(wr_data);
        m_known[back][wr_addr] = 1;
      end
      m_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_addr) < DEPTH) begin
          m_rd = m_mem[m_front][rd_addr];
          m_rd_known = m_known[m_front][rd_addr];
        end else begin
          m_rd = 0;
          m_rd_known = 1;
        end
      end
      if (m_ack) begin
        m_ack = 0;
`ifdef BANK_CLEAR_EN
        m_clear_left = DEPTH;
`endif
      end else if (m_pend) begin
        if (!rd_en) begin
          m_front = 1 - m_front; m_pend = 0; m_ack = 1;
        end
      end else if (busy) begin
        m_mem[back][DEPTH - m_clear_left] = 0;
        m_known[back][DEPTH - m_clear_left] = 1;
        m_clear_left--;
        if (swap_req) m_latch = 1;
      end else if (swap_req || m_latch) begin
        m_latch = 0;
        if (!rd_en) begin
          m_front = 1 - m_front; m_ack = 1;
        end else begin
          m_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
    chk("front_bank", 32'(front_bank), 32'(m_front));
    chk("clear_busy", 32'(clear_busy), 32'(m_clear_left > 0));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
  end

  task automatic wait_clear();
    for (int i = 0; i < 5000 && clear_busy; i++) @(negedge clk);
    if (clear_busy) chk("clear_timeout", 32'(clear_busy), 32'd0);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_front", 32'(front_bank), 32'd0);
    chk("rst_swap_ack", 32'(swap_ack), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill back bank, swap with reader idle, read back.
    wr_en = 1; wr_addr = 12'h005; wr_data = 4'hA;
    @(negedge clk);
    wr_addr = 12'h010; wr_data = 4'h6;
    @(negedge clk);
    wr_en = 0; swap_req = 1;
    @(negedge clk);
    swap_req = 0;
    chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
    chk("front_after_swap", 32'(front_bank), 32'd1);
    @(negedge clk);
    chk("swap_ack_drop", 32'(swap_ack), 32'd0);
    wait_clear();
    rd_en = 1; rd_addr = 12'h005;
    @(negedge clk);
    chk("read_005", 32'(rd_data), 32'hA);
    chk("read_005_valid", 32'(rd_valid), 32'd1);

    // Write to the back bank must not be visible to the reader.
    rd_en = 0; wr_en = 1; wr_addr = 12'h010; wr_data = 4'h3;
    @(negedge clk);
    wr_en = 0; rd_en = 1; rd_addr = 12'h010;
    @(negedge clk);
    chk("read_010_old", 32'(rd_data), 32'h6);

    // Swap requested while reader is busy waits for the first idle edge.
    swap_req = 1; rd_addr = 12'h005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      swap_req = 0;
      chk("pend_front", 32'(front_bank), 32'd1);
      chk("pend_no_ack", 32'(swap_ack), 32'd0);
    end
    rd_en = 0;
    @(negedge clk);
    chk("pend_front_toggle", 32'(front_bank), 32'd0);
    chk("pend_ack", 32'(swap_ack), 32'd1);
    @(negedge clk);
    chk("pend_ack_drop", 32'(swap_ack), 32'd0);
    wait_clear();

    // Reset while pending discards the swap.
    swap_req = 1;
    @(negedge clk);
    swap_req = 0;
    @(negedge clk);
    wait_clear();
    swap_req = 1; rd_en = 1;
    @(negedge clk);
    swap_req = 0;
    #2 reset_n = 1'b0;
    #2 chk("rst_pend_front", 32'(front_bank), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; rd_en = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_pend_no_ack", 32'(swap_ack), 32'd0);
      chk("rst_pend_front0", 32'(front_bank), 32'd0);
    end

    // Randomised traffic on a small address pool so reads hit written words.
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_data  = DATA_W'($urandom);
      wr_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFF - $urandom_range(0, 3))
                                              : ADDR_W'($urandom_range(0, 15));
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFF - $urandom_range(0, 3))
                                              : ADDR_W'($urandom_range(0, 15));
      swap_req = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    wr_en = 0; rd_en = 0; swap_req = 0;
    @(negedge clk);
    @(negedge clk);
    wait_clear();

`ifdef BANK_CLEAR_EN
    wr_en = 1; wr_addr = 12'hFFF; wr_data = 4'hF;
    @(negedge clk);
    wr_en = 0; swap_req = 1;
    @(negedge clk);
    swap_req = 0;
    chk("clr_swap_ack", 32'(swap_ack), 32'd1);
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      wr_en = 0;
      if (!clear_busy) break;
      cnt++;
      if (cnt == 4000) begin
        wr_en = 1; wr_addr = 12'h007; wr_data = 4'h9;
      end
    end
    chk("clr_window_len", 32'(cnt), 32'd4096);
    swap_req = 1;
    @(negedge clk);
    swap_req = 0;
    @(negedge clk);
    wait_clear();
    rd_en = 1; rd_addr = 12'hFFF;
    @(negedge clk);
    chk("clr_read_fff", 32'(rd_data), 32'd0);
    rd_addr = 12'h007;
    @(negedge clk);
    chk("clr_dropped_wr", 32'(rd_data), 32'd0);
    rd_en = 0;
    @(negedge clk);
`else
    cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
